// File: rtl/term_accumulator_if.sv
// Handshake bundle for term_accumulator: burst start, term input stream and result output.
interface term_accumulator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  term_count;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_sum;
  logic                  out_ovf;
  logic                  busy;

  modport master (
    output start, term_count, in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, term_count, in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/term_accumulator.sv
// Saturating burst accumulator built around a carry-select add/sub.
// Accepts one signed term per cycle and returns the sum over valid/ready.
module add_sub #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         ovf
);
  localparam int H = W / 2;

  logic [H:0]   lo;
  logic [H-1:0] hi0, hi1;

  // Upper half is precomputed for both carries; the low-half carry selects.
  assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign hi0 = a[W-1:H] + b[W-1:H];
  assign hi1 = a[W-1:H] + b[W-1:H] + {{(H-1){1'b0}}, 1'b1};
  assign sum = {(lo[H] ? hi1 : hi0), lo[H-1:0]};
  assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
endmodule

module term_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  term_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  sticky;
  logic                  in_ready_q, out_valid_q, busy_q;

  logic [DATA_WIDTH-1:0] b_op, add_sum, sat_val;
  logic                  add_ovf;

  assign b_op = bus.in_sub ? ~bus.in_data : bus.in_data;

  add_sub #(.W(DATA_WIDTH)) u_add_sub (
    .a   (acc),
    .b   (b_op),
    .cin (bus.in_sub),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Clamp toward the sign of the running sum so no wrap is ever visible.
  assign sat_val = !add_ovf ? add_sum :
                   acc[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      remaining   <= '0;
      sticky      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          acc       <= '0;
          sticky    <= 1'b0;
          remaining <= bus.term_count;
          busy_q    <= 1'b1;
          if (bus.term_count != '0) begin
            state      <= ACCUM;
            in_ready_q <= 1'b1;
          end else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        ACCUM: if (bus.in_valid) begin
          acc       <= sat_val;
          sticky    <= sticky | add_ovf;
          remaining <= remaining - CNT_WIDTH'(1);
          if (remaining == CNT_WIDTH'(1)) begin
            state       <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = sticky;
  assign bus.busy      = busy_q;
endmodule
